// File: rtl/guitar_pkg.sv
// rtl/guitar_pkg.sv - shared state encoding and scoring constants for note_highway
package guitar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } hw_state_t;

    localparam int SCORE_PER_HIT = 10;
    localparam int COMBO_STEP    = 8;
    localparam int MAX_MULT      = 4;

`ifdef NOTE_HIGHWAY_MULT_EN
    // Combo-driven score multiplier, capped so long streaks stop paying extra.
    function automatic logic [31:0] hit_mult(input logic [31:0] combo_val);
        logic [31:0] m;
        m = 32'd1 + combo_val / 32'(COMBO_STEP);
        if (m > 32'(MAX_MULT)) begin
            m = 32'(MAX_MULT);
        end
        return m;
    endfunction
`endif

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with rising-edge pulse output
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Metastability filter followed by one history flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/note_highway.sv
// rtl/note_highway.sv - scrolling note field, hit judging, score and combo (NOTE_HIGHWAY_MULT_EN enables combo multiplier)
module note_highway
    import guitar_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int ROWS    = 16,
    parameter int SCORE_W = 16,
    parameter int COMBO_W = 8
) (
    input  logic                     in_clk,
    input  logic                     rst,
    input  logic                     step_clk,
    input  logic                     run,
    input  logic [LANES-1:0]         note_in,
    input  logic                     song_end,
    input  logic [LANES-1:0]         buttons,
    output logic                     note_req,
    output logic [LANES*ROWS-1:0]    field,
    output logic [SCORE_W-1:0]       score,
    output logic [COMBO_W-1:0]       combo,
    output logic                     hit,
    output logic                     miss,
    output logic [1:0]               state
);

    localparam int DRAIN_W = $clog2(ROWS + 1);
    localparam int HIT_W   = $clog2(LANES + 1);
    localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);
    localparam logic [31:0] COMBO_MAX = 32'((64'd1 << COMBO_W) - 64'd1);

    hw_state_t cur;
    hw_state_t nxt;

    logic               step_rise;
    logic [LANES-1:0]   press_rise;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               draining;
    logic               drain_full;

    logic               active;
    logic               do_step;
    logic               drain_now;
    logic [LANES-1:0]   presses;
    logic [LANES-1:0]   hits;
    logic [LANES-1:0]   row0_left;
    logic [LANES-1:0]   top_row;
    logic               bad_press;
    logic               dropped;
    logic               any_miss;
    logic [HIT_W-1:0]   hit_cnt;
    logic [31:0]        incr;
    logic [31:0]        score_sum;
    logic [31:0]        combo_sum;
    logic [SCORE_W-1:0] score_new;
    logic [COMBO_W-1:0] combo_new;
    logic [LANES*ROWS-1:0] field_next;

    sync_edge u_step_sync (
        .clk  (in_clk),
        .rst  (rst),
        .din  (step_clk),
        .rise (step_rise)
    );

    for (genvar l = 0; l < LANES; l++) begin : g_btn_sync
        sync_edge u_btn_sync (
            .clk  (in_clk),
            .rst  (rst),
            .din  (buttons[l]),
            .rise (press_rise[l])
        );
    end

    assign drain_full = (drain_cnt == DRAIN_W'(ROWS));
    assign state      = cur;

    // State register.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            cur <= ST_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state: a finished drain wins over a pause request.
    always_comb begin
        nxt = cur;
        case (cur)
            ST_IDLE:  if (run) nxt = ST_PLAY;
            ST_PLAY: begin
                if (drain_full)  nxt = ST_DONE;
                else if (!run)   nxt = ST_PAUSE;
            end
            ST_PAUSE: if (run) nxt = ST_PLAY;
            ST_DONE:  if (!run) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    // Judge presses against the pre-shift hit row, then scroll the field.
    always_comb begin
        active    = (cur == ST_PLAY);
        do_step   = active & step_rise;
        drain_now = draining | song_end;
        presses   = active ? press_rise : '0;
        hits      = presses & field[LANES-1:0];
        bad_press = |(presses & ~field[LANES-1:0]);
        row0_left = field[LANES-1:0] & ~hits;
        dropped   = do_step & (|row0_left);
        any_miss  = bad_press | dropped;
        top_row   = drain_now ? '0 : note_in;

        field_next = field;
        field_next[LANES-1:0] = row0_left;
        if (do_step) begin
            field_next = {top_row, field_next[LANES*ROWS-1:LANES]};
        end
    end

    // Count simultaneous hits so score and combo credit every lane.
    always_comb begin
        hit_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            hit_cnt = hit_cnt + HIT_W'(hits[l]);
        end
    end

    // Saturating score and combo updates; the multiplier sees the pre-update combo.
    always_comb begin
`ifdef NOTE_HIGHWAY_MULT_EN
        incr = 32'(SCORE_PER_HIT) * hit_mult(32'(combo));
`else
        incr = 32'(SCORE_PER_HIT);
`endif
        score_sum = 32'(score) + incr * 32'(hit_cnt);
        combo_sum = 32'(combo) + 32'(hit_cnt);
        score_new = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
        combo_new = (combo_sum > COMBO_MAX) ? COMBO_MAX[COMBO_W-1:0] : combo_sum[COMBO_W-1:0];
    end

    // Field, score, combo, drain tracking and one-cycle event pulses.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            field     <= '0;
            score     <= '0;
            combo     <= '0;
            drain_cnt <= '0;
            draining  <= 1'b0;
            note_req  <= 1'b0;
            hit       <= 1'b0;
            miss      <= 1'b0;
        end else begin
            note_req <= 1'b0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            if (cur == ST_IDLE && run) begin
                field     <= '0;
                score     <= '0;
                combo     <= '0;
                drain_cnt <= '0;
                draining  <= 1'b0;
            end else if (active) begin
                field <= field_next;
                score <= score_new;
                combo <= any_miss ? '0 : combo_new;
                hit   <= |hits;
                miss  <= any_miss;
                if (do_step) begin
                    note_req <= ~drain_now;
                    if (drain_now) begin
                        draining <= 1'b1;
                        if (!drain_full) begin
                            drain_cnt <= drain_cnt + DRAIN_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_note_highway.sv
// tb/tb_note_highway.sv - table-driven scoreboard bench for note_highway
module tb_note_highway;

    localparam int LANES   = 4;
    localparam int ROWS    = 16;
    localparam int SCORE_W = 16;
    localparam int COMBO_W = 8;
    localparam int NF      = LANES * ROWS;
`ifdef NOTE_HIGHWAY_MULT_EN
    localparam int BONUS = 20;
`else
    localparam int BONUS = 10;
`endif

    logic               in_clk;
    logic               rst;
    logic               step_clk;
    logic               run;
    logic [LANES-1:0]   note_in;
    logic               song_end;
    logic [LANES-1:0]   buttons;
    logic               note_req;
    logic [NF-1:0]      field;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    logic               hit;
    logic               miss;
    logic [1:0]         state;

    note_highway #(
        .LANES   (LANES),
        .ROWS    (ROWS),
        .SCORE_W (SCORE_W),
        .COMBO_W (COMBO_W)
    ) dut (
        .in_clk   (in_clk),
        .rst      (rst),
        .step_clk (step_clk),
        .run      (run),
        .note_in  (note_in),
        .song_end (song_end),
        .buttons  (buttons),
        .note_req (note_req),
        .field    (field),
        .score    (score),
        .combo    (combo),
        .hit      (hit),
        .miss     (miss),
        .state    (state)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    typedef struct {
        logic       step;
        logic [3:0] btn;
        logic [3:0] note;
        logic       send;
        logic       hit;
        logic       miss;
        logic       req;
        int         sc;
        int         cb;
    } vec_t;

    typedef struct {
        logic          hit;
        logic          miss;
        logic          req;
        int            sc;
        int            cb;
        logic [NF-1:0] fld;
    } exp_t;

    vec_t          tbl[$];
    exp_t          sb[$];
    logic [NF-1:0] mf;
    logic [3:0]    lead_notes [7];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic add(input logic st, input logic [3:0] b, input logic [3:0] n, input logic se,
                       input logic eh, input logic em, input logic er, input int es, input int ec);
        vec_t v;
        v.step = st; v.btn = b; v.note = n; v.send = se;
        v.hit = eh; v.miss = em; v.req = er; v.sc = es; v.cb = ec;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic model_apply(input vec_t v);
        mf[LANES-1:0] = mf[LANES-1:0] & ~v.btn;
        if (v.step) begin
            for (int r = 0; r < ROWS - 1; r++) begin
                mf[r*LANES +: LANES] = mf[(r+1)*LANES +: LANES];
            end
            mf[(ROWS-1)*LANES +: LANES] = v.send ? 4'b0000 : v.note;
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        model_apply(v);
        e.hit = v.hit; e.miss = v.miss; e.req = v.req;
        e.sc = v.sc; e.cb = v.cb; e.fld = mf;
        sb.push_back(e);
        step_clk = v.step;
        buttons  = v.btn;
        note_in  = v.note;
        song_end = v.send;
        tick(); tick(); tick();
        if (sb.size() == 0) begin
            chk($sformatf("v%0d.scoreboard_empty", idx), 64'(1), 64'(0));
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d.hit", idx),      64'(hit),      64'(e.hit));
            chk($sformatf("v%0d.miss", idx),     64'(miss),     64'(e.miss));
            chk($sformatf("v%0d.note_req", idx), 64'(note_req), 64'(e.req));
            chk($sformatf("v%0d.score", idx),    64'(score),    64'(e.sc));
            chk($sformatf("v%0d.combo", idx),    64'(combo),    64'(e.cb));
            chk($sformatf("v%0d.field", idx),    64'(field),    64'(e.fld));
        end
        step_clk = 1'b0;
        buttons  = '0;
        tick();
        chk($sformatf("v%0d.pulses_end", idx), 64'({hit, miss, note_req}), 64'(0));
        tick(); tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        lead_notes[0] = 4'b1111;
        lead_notes[1] = 4'b1111;
        lead_notes[2] = 4'b0001;
        lead_notes[3] = 4'b0010;
        lead_notes[4] = 4'b1000;
        lead_notes[5] = 4'b0001;
        lead_notes[6] = 4'b0001;
        for (int k = 0; k < ROWS; k++) begin
            add(1'b1, 4'b0000, (k < 7) ? lead_notes[k] : 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        end
        add(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 40, 4);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 40, 4);
        add(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 80, 8);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 80, 8);
        add(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 80 + BONUS, 9);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 80 + BONUS, 9);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 80 + BONUS, 0);
        add(1'b1, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 90 + BONUS, 1);
        add(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 100 + BONUS, 2);
        add(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 100 + BONUS, 0);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 100 + BONUS, 0);
        add(1'b0, 4'b0101, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 110 + BONUS, 0);
        for (int k = 0; k < ROWS; k++) begin
            add(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 110 + BONUS, 0);
        end

        rst = 1'b0; run = 1'b1; step_clk = 1'b0;
        note_in = '0; song_end = 1'b0; buttons = '0;
        for (int i = 0; i < 6; i++) begin
            step_clk = ~step_clk;
            tick();
        end
        chk("reset.state",  64'(state), 64'(0));
        chk("reset.field",  64'(field), 64'(0));
        chk("reset.score",  64'(score), 64'(0));
        chk("reset.combo",  64'(combo), 64'(0));
        chk("reset.pulses", 64'({hit, miss, note_req}), 64'(0));
        step_clk = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("release.state_play", 64'(state), 64'(1));
        mf = '0;

        for (int i = 0; i < ROWS + 12; i++) begin
            apply(tbl[i], i);
        end

        run = 1'b0;
        tick();
        chk("pause.state", 64'(state), 64'(2));
        step_clk = 1'b1; note_in = 4'b1111; buttons = 4'b0100;
        tick(); tick(); tick();
        chk("pause.field_held", 64'(field), 64'(mf));
        chk("pause.pulses",     64'({hit, miss, note_req}), 64'(0));
        step_clk = 1'b0; buttons = '0;
        tick(); tick(); tick();
        run = 1'b1;
        tick();
        chk("resume.state", 64'(state), 64'(1));
        chk("resume.field", 64'(field), 64'(mf));
        chk("resume.score", 64'(score), 64'(110 + BONUS));

        for (int i = ROWS + 12; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end
        chk("drain.state_done", 64'(state), 64'(3));
        chk("drain.field_empty", 64'(field), 64'(0));
        run = 1'b0;
        tick();
        chk("done.state_idle", 64'(state), 64'(0));
        run = 1'b1; song_end = 1'b0;
        tick();
        chk("restart.state", 64'(state), 64'(1));
        chk("restart.score", 64'(score), 64'(0));
        chk("restart.combo", 64'(combo), 64'(0));

        step_clk = 1'b1; note_in = 4'b1010;
        tick(); tick(); tick();
        chk("midsong.note_req", 64'(note_req), 64'(1));
        chk("midsong.field",    64'(field), 64'({4'b1010, {(NF-4){1'b0}}}));
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset.field",    64'(field), 64'(0));
        chk("async_reset.note_req", 64'(note_req), 64'(0));
        chk("async_reset.state",    64'(state), 64'(0));
        step_clk = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_highway.md
# note_highway

Gameplay core downstream of `clock_divider`: consumes its divided `out_clk` as a scroll-rate strobe and advances a LANES×ROWS note field one row per rising edge. It loads new rows from the song source at the top and judges player button presses against the bottom row. It also maintains score and combo. Display and audio blocks read its outputs.

## Interface
- `LANES`, 4: number of note lanes/buttons
- `ROWS`, 16: field depth; row 0 is the hit row
- `SCORE_W`, 16: score counter width
- `COMBO_W`, 8: combo counter width
- `in_clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `step_clk`  in  1  divided clock from `clock_divider.out_clk`; asynchronous-safe, treated as data
- `run`  in  1  high = play, low = pause / return
- `note_in`  in  LANES  next top row from song ROM
- `song_end`  in  1  song ROM exhausted
- `buttons`  in  LANES  debounced fret buttons, high = pressed
- `note_req`  out  1  one-cycle pulse: advance song ROM address
- `field`  out  LANES*ROWS  note field; bit `r*LANES+l` = row r, lane l
- `score`  out  SCORE_W  accumulated score
- `combo`  out  COMBO_W  consecutive-hit count
- `hit`  out  1  one-cycle pulse, ≥1 note hit this cycle
- `miss`  out  1  one-cycle pulse, ≥1 miss this cycle
- `state`  out  2  FSM state

## Operation
- States: IDLE=0, PLAY=1, PAUSE=2, DONE=3.
- IDLE→PLAY on `run`=1: field, score, combo, and drain counter cleared in the transition cycle.
- PLAY→PAUSE on `run`=0. PAUSE→PLAY on `run`=1 with no clearing. In PAUSE, steps and button edges are ignored.
- PLAY→DONE when drain counter reaches ROWS. DONE→IDLE on `run`=0.
- `step` event: synchronized rising edge of `step_clk`, acted on in PLAY only.
  - Row r takes row r+1; row 0 is discarded.
  - Top row takes `note_in`, or zeros when draining.
  - `note_req` pulses in the same cycle.
- Drain:
  - `song_end` sampled high at a step sets draining. `note_req` is suppressed from then on.
  - Each step while draining increments the drain counter.
- Press event: synchronized rising edge of `buttons[l]` in PLAY.
  - If row 0 lane l is set: hit. Clear the cell, add the increment to score, and increment combo.
  - Otherwise: miss. Set combo to 0; score is unchanged.
- Step discard: any set cell in row 0 at a step is a missed note. Set combo to 0.
- Simultaneous events:
  - Presses are judged against the pre-shift row 0. The hit cell is cleared before the shift, so it is not counted as a missed note.
  - A hit and a miss in the same cycle leave combo at 0. `hit` and `miss` both pulse.
- Multiple hits in one cycle: score adds increment × hit count; combo adds the hit count.
- Arithmetic: score and combo saturate at all-ones and never wrap.

## Timing
- Reset values: `field`=0, `score`=0, `combo`=0, `note_req`=0, `hit`=0, `miss`=0, `state`=IDLE. All synchronizers cleared.
- `step_clk` rising edge → step action on the 3rd `in_clk` edge (2-flop sync + edge register). `buttons` have the same 3-cycle latency.
- `field`, `score`, `combo`, `hit`, `miss`, and `note_req` are registered. They update on the edge that performs the action.
- `note_in` must be valid at the step edge. The ROM has until the next step to present the following row.
- Reset asserted mid-song: everything returns to reset values immediately; no pending pulses survive.

## Configuration
- `NOTE_HIGHWAY_MULT_EN` defined: per-hit increment = SCORE_PER_HIT × min(1 + combo/COMBO_STEP, MAX_MULT). The pre-update combo is used.
- Undefined: per-hit increment is fixed at SCORE_PER_HIT; the multiplier logic is absent.

## Structure
- Shared package `guitar_pkg`:
  - state enum
  - SCORE_PER_HIT=10
  - COMBO_STEP=8
  - MAX_MULT=4
- Sub-module `sync_edge`: 2-flop synchronizer plus rising-edge detector, async active-low reset. Instantiated LANES+1 times (buttons + `step_clk`).

## Test plan
- Reset with `step_clk` toggling and `run`=1 → all outputs at reset values; after release, state=PLAY within 1 cycle.
- Play pattern:
  - Stimulus: `note_in`=4'b0001 on one step, then 0, for ROWS steps.
  - Required: the note reaches row 0 after ROWS-1 steps.
  - Required: pressing lane 0 there gives `hit`, score=10, combo=1, and row 0 cleared.
- Unplayed note → at discard step, `miss` pulses and combo=0; score unchanged.
- Lane 2 press with empty row 0 → `miss`, combo resets from 5 to 0.
- Press and step in the same cycle on a row-0 note → counted as a hit only; no missed note.
- `song_end`=1, then ROWS steps:
  - Required: no `note_req` after `song_end`, field empties, state=DONE.
  - With `NOTE_HIGHWAY_MULT_EN` and combo=8, the next hit adds 20.
